coreahblite_master_arb: RTL and testbench

//  Multi-master AHB-Lite bus arbiter in front of the CoreAHBLite slave address decoder.

---
 rtl/coreahblite_master_arb.sv | 89 ++++++++
 tb/tb_coreahblite_master_arb.sv | 104 ++++++++++
 2 files changed

// File: rtl/coreahblite_master_arb.sv
// coreahblite_master_arb: multi-master AHB-Lite arbiter with lock and hold-limit support
module coreahblite_master_arb #(
   parameter int NUM_MASTERS    = 4,
   parameter int ARB_MODE       = 0,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_HOLD       = 16
) (
   input  logic                     hclk,
   input  logic                     hresetn,
   input  logic [NUM_MASTERS-1:0]   hreq,
   input  logic [NUM_MASTERS-1:0]   hlock,
   input  logic [2*NUM_MASTERS-1:0] htrans_m,
   input  logic                     hready,
   output logic [NUM_MASTERS-1:0]   hgrant,
   output logic [1:0]               hmaster,
   output logic [1:0]               hmaster_d,
   output logic                     hmastlock
);
   localparam logic [1:0] PARK   = 2'd0;
   localparam logic [1:0] OWN    = 2'd1;
   localparam logic [1:0] LOCK   = 2'd2;
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [1:0] DEF    = 2'(DEFAULT_MASTER);
   localparam logic [7:0] MAXC   = 8'(MAX_HOLD);
   localparam logic [NUM_MASTERS-1:0] DEF_G = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [1:0] state, nxt_state, own, win, nxt_owner, free_state;
   logic [7:0] cnt, tr;
   logic [3:0] req, lk, oth, cand;
   logic [2:0] idx;
   logic       sat, ap, chg, unlock, busy_burst;

   // Inputs are zero-padded to four masters so the owner can be indexed uniformly
   assign req        = 4'(hreq);
   assign lk         = 4'(hlock);
   assign tr         = 8'(htrans_m);
   assign own        = tr[{hmaster, 1'b0} +: 2];
   assign busy_burst = own == SEQ || own == BUSY;
   assign sat        = cnt == MAXC;
   assign oth        = req & ~(4'b0001 << hmaster);
   assign unlock     = !lk[hmaster] && (own == IDLE || own == NONSEQ);
   assign ap         = hready && !busy_burst && (!hmastlock || unlock) &&
                       (own == IDLE || !req[hmaster] || (sat && |oth));
   assign cand       = (sat && |oth) ? oth : req;
   assign chg        = ap && win != hmaster;
   assign nxt_owner  = ap ? win : hmaster;
   assign free_state = (nxt_owner == DEF && req == 4'd0) ? PARK : OWN;
   assign nxt_state  = chg ? free_state :
                       state == LOCK ? (unlock ? free_state : LOCK) :
                       (state == OWN && lk[hmaster]) ? LOCK : free_state;

   // Winner selection; descending loops let the highest-priority candidate be assigned last
   always_comb begin
      win = DEF;
      idx = 3'd0;
      if (ARB_MODE == 1) begin
         for (int i = NUM_MASTERS - 1; i >= 0; i--)
            if (cand[i]) win = 2'(i);
      end else begin
         for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = 3'(hmaster) + 3'(k);
            if (idx >= 3'(NUM_MASTERS)) idx = idx - 3'(NUM_MASTERS);
            if (cand[idx[1:0]]) win = idx[1:0];
         end
      end
   end

   // Grant, owner pipeline, lock flag and hold counter all advance only on HREADY edges
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state     <= PARK;
         hgrant    <= DEF_G;
         hmaster   <= DEF;
         hmaster_d <= DEF;
         hmastlock <= 1'b0;
         cnt       <= 8'd0;
      end else if (hready) begin
         state     <= nxt_state;
         hgrant    <= NUM_MASTERS'(4'b0001 << nxt_owner);
         hmaster   <= nxt_owner;
         hmaster_d <= hmaster;
         hmastlock <= nxt_state == LOCK;
         cnt       <= chg ? 8'd0 : (own[1] && !sat) ? cnt + 8'd1 : cnt;
      end
   end
endmodule

// File: tb/tb_coreahblite_master_arb.sv
// tb_coreahblite_master_arb: scoreboard bench for the AHB-Lite master arbiter
module tb_coreahblite_master_arb;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;

   typedef struct packed {
      logic [1:0] m;
      logic [1:0] md;
      logic       l;
   } exp_t;

   logic       hclk = 1'b0;
   logic       hresetn = 1'b0;
   logic [3:0] hreq = '0, hlock = '0;
   logic [7:0] htrans_m = '0;
   logic       hready = 1'b1;
   logic [3:0] hgrant;
   logic [1:0] hmaster, hmaster_d;
   logic       hmastlock;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   string      phase = "init";

   coreahblite_master_arb #(
      .NUM_MASTERS(4), .ARB_MODE(0), .DEFAULT_MASTER(0), .MAX_HOLD(4)
   ) dut (
      .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock),
      .htrans_m(htrans_m), .hready(hready), .hgrant(hgrant),
      .hmaster(hmaster), .hmaster_d(hmaster_d), .hmastlock(hmastlock)
   );

   always #5 hclk = ~hclk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s got %0h expected %0h", phase, tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ht(input int m, input logic [1:0] t);
      return 8'(t) << (2 * m);
   endfunction

   // Drive one cycle of inputs, queue the expected owners, compare after the edge
   task automatic step(input logic rst_n, input logic rdy, input logic [3:0] rq,
                       input logic [3:0] lkv, input logic [7:0] tr,
                       input logic [1:0] em, input logic [1:0] emd, input logic el);
      exp_t e;
      hresetn  = rst_n;
      hready   = rdy;
      hreq     = rq;
      hlock    = lkv;
      htrans_m = tr;
      sb.push_back('{m: em, md: emd, l: el});
      @(posedge hclk);
      #1;
      e = sb.pop_front();
      check_val("hgrant", 8'(hgrant), 8'(4'b0001 << e.m));
      check_val("hmaster", 8'(hmaster), 8'(e.m));
      check_val("hmaster_d", 8'(hmaster_d), 8'(e.md));
      check_val("hmastlock", 8'(hmastlock), 8'(e.l));
   endtask

   initial begin
      phase = "reset";
      repeat (2) step(0, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
      step(0, 0, 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
      phase = "park";
      repeat (10) step(1, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
      phase = "rr";
      step(1, 1, 4'b0110, 4'b0000, 8'h00, 1, 0, 0);
      step(1, 1, 4'b0110, 4'b0000, 8'h00, 2, 1, 0);
      step(1, 1, 4'b0110, 4'b0000, 8'h00, 1, 2, 0);
      step(1, 1, 4'b0110, 4'b0000, 8'h00, 2, 1, 0);
      phase = "stall";
      repeat (3) step(1, 0, 4'b0110, 4'b0000, 8'h00, 2, 1, 0);
      step(1, 1, 4'b0110, 4'b0000, 8'h00, 1, 2, 0);
      phase = "burst";
      step(1, 1, 4'b0100, 4'b0000, 8'h00, 2, 1, 0);
      step(1, 1, 4'b0101, 4'b0000, ht(2, NSQ), 2, 2, 0);
      step(1, 1, 4'b0101, 4'b0000, ht(2, SQ), 2, 2, 0);
      step(1, 1, 4'b0101, 4'b0000, ht(2, BUSY), 2, 2, 0);
      repeat (2) step(1, 1, 4'b0101, 4'b0000, ht(2, SQ), 2, 2, 0);
      step(1, 1, 4'b0101, 4'b0000, ht(2, IDLE), 0, 2, 0);
      phase = "hold";
      step(1, 1, 4'b0010, 4'b0000, 8'h00, 1, 0, 0);
      repeat (4) step(1, 1, 4'b1010, 4'b0000, ht(1, NSQ), 1, 1, 0);
      step(1, 1, 4'b1010, 4'b0000, ht(1, NSQ), 3, 1, 0);
      check_val("hold_cnt", dut.cnt, 8'd0);
      phase = "lock";
      step(1, 1, 4'b1111, 4'b0001, ht(0, NSQ), 0, 3, 0);
      repeat (19) step(1, 1, 4'b1111, 4'b0001, ht(0, NSQ), 0, 0, 1);
      step(1, 1, 4'b1111, 4'b0001, ht(0, IDLE), 0, 0, 1);
      step(1, 1, 4'b1111, 4'b0000, ht(0, SQ), 0, 0, 1);
      step(1, 1, 4'b1111, 4'b0000, ht(0, IDLE), 1, 0, 0);
      phase = "reset2";
      step(0, 0, 4'b1111, 4'b0000, ht(1, NSQ), 0, 0, 0);
      step(1, 1, 4'b0000, 4'b0000, 8'h00, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
